// File: rtl/gmii_udp_video_rx.sv
// GMII receiver for UDP-carried video: parses Ethernet/IPv4/UDP headers, steers by
// UDP destination port to one of NUM_CH channels and packs payload into pixel words.
module gmii_udp_video_rx #(
  parameter logic [31:0] IPV4_DST      = 32'hC0A80001,
  parameter logic [15:0] DST_PORT_BASE = 16'd12345,
  parameter int          NUM_CH        = 2,
  parameter int          CH_W          = 4,
  parameter int          PIXEL_BYTES   = 2,
  parameter int          MAX_PAYLOAD   = 1280
) (
  input  logic                     clk125,
  input  logic                     sys_rst_n,
  input  logic [7:0]               rxd,
  input  logic                     rx_dv,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [8*PIXEL_BYTES-1:0] pix_data,
  output logic [CH_W-1:0]          pix_ch,
  output logic [11:0]              pix_y,
  output logic [3:0]               pix_x,
  output logic                     pix_valid,
  output logic                     pkt_start,
  output logic                     pkt_done,
  output logic                     pkt_err,
  output logic [15:0]              drop_cnt,
  output logic [2:0]               state_dbg
);

  // Pixel output handshake: pix_valid is a one-cycle strobe qualifying pix_*; there is
  // no ready, the consumer must take every strobed word.
  typedef enum logic [2:0] {S_DROP, S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD} state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD + 10);

  state_t                      state;
  logic [5:0]                  idx;
  logic [15:0]                 ethertype;
  logic [7:0]                  ver_ihl;
  logic [7:0]                  proto;
  logic [31:0]                 dst_ip;
  logic [15:0]                 dst_port;
  logic [7:0]                  len_hi;
  logic [7:0]                  y_lo;
  logic [11:0]                 hdr_y;
  logic [3:0]                  hdr_x;
  logic                        accepted;
  logic [CH_W-1:0]             ch_q;
  logic [15:0]                 rem;
  logic [1:0]                  pcnt;
  logic [8*(PIXEL_BYTES-1)-1:0] pack;

  logic [15:0]                 port_off;
  logic [15:0]                 en_ext;
  logic [15:0]                 udp_len;
  logic                        hdr_ok;
  logic [8*PIXEL_BYTES-1:0]    pix_next;

  assign state_dbg = state;
  assign port_off  = dst_port - DST_PORT_BASE;
  assign en_ext    = 16'(ch_en);
  assign udp_len   = {len_hi, rxd};
  assign pix_next  = {pack, rxd};

  // Low length byte arrives on the decision cycle, so it is checked straight off rxd.
  assign hdr_ok = (ethertype == 16'h0800) && (ver_ihl == 8'h45) && (proto == 8'h11) &&
                  (dst_ip == IPV4_DST) && (port_off < 16'(NUM_CH)) &&
                  en_ext[port_off[3:0]] && (udp_len >= 16'd10) && (udp_len <= MAX_LEN);

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_DROP;
      idx       <= '0;
      ethertype <= '0;
      ver_ihl   <= '0;
      proto     <= '0;
      dst_ip    <= '0;
      dst_port  <= '0;
      len_hi    <= '0;
      y_lo      <= '0;
      hdr_y     <= '0;
      hdr_x     <= '0;
      accepted  <= 1'b0;
      ch_q      <= '0;
      rem       <= '0;
      pcnt      <= '0;
      pack      <= '0;
      pix_data  <= '0;
      pix_ch    <= '0;
      pix_y     <= '0;
      pix_x     <= '0;
      pix_valid <= 1'b0;
      pkt_start <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      pix_valid <= 1'b0;
      pkt_start <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      case (state)
        S_DROP: if (!rx_dv) state <= S_IDLE;
        S_IDLE: if (rx_dv && rxd == 8'h55) state <= S_PREAMBLE;
        S_PREAMBLE: begin
          if (!rx_dv) state <= S_IDLE;
          else if (rxd == 8'hD5) begin
            state    <= S_HEADER;
            idx      <= '0;
            accepted <= 1'b0;
          end else if (rxd != 8'h55) state <= S_DROP;
        end
        S_HEADER: begin
          if (!rx_dv) begin
            state <= S_IDLE;
            if (accepted) pkt_err <= 1'b1;
            else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end else begin
            idx <= idx + 6'd1;
            case (idx)
              6'd12: ethertype[15:8] <= rxd;
              6'd13: ethertype[7:0]  <= rxd;
              6'd14: ver_ihl         <= rxd;
              6'd23: proto           <= rxd;
              6'd30: dst_ip[31:24]   <= rxd;
              6'd31: dst_ip[23:16]   <= rxd;
              6'd32: dst_ip[15:8]    <= rxd;
              6'd33: dst_ip[7:0]     <= rxd;
              6'd36: dst_port[15:8]  <= rxd;
              6'd37: dst_port[7:0]   <= rxd;
              6'd38: len_hi          <= rxd;
              6'd39: begin
                if (hdr_ok) begin
                  accepted <= 1'b1;
                  ch_q     <= port_off[CH_W-1:0];
                  rem      <= udp_len - 16'd10;
                end else begin
                  state <= S_DROP;
                  if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end
              end
              6'd42: y_lo <= rxd;
              6'd43: begin
                hdr_y     <= {rxd[3:0], y_lo};
                hdr_x     <= rxd[7:4];
                pkt_start <= 1'b1;
                pcnt      <= '0;
                state     <= S_PAYLOAD;
              end
              default: ;
            endcase
          end
        end
        S_PAYLOAD: begin
          if (rem == 16'd0) begin
            pkt_done <= 1'b1;
            state    <= rx_dv ? S_DROP : S_IDLE;
          end else if (!rx_dv) begin
            pkt_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            rem  <= rem - 16'd1;
            pack <= pix_next[8*(PIXEL_BYTES-1)-1:0];
            if (pcnt == 2'(PIXEL_BYTES - 1)) begin
              pcnt      <= '0;
              pix_valid <= 1'b1;
              pix_data  <= pix_next;
              pix_ch    <= ch_q;
              pix_y     <= hdr_y;
              pix_x     <= hdr_x;
            end else pcnt <= pcnt + 2'd1;
            // Trailing bytes short of a full pixel simply never reach pix_data.
            if (rem == 16'd1) begin
              pkt_done <= 1'b1;
              state    <= S_DROP;
            end
          end
        end
        default: state <= S_DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_udp_video_rx.sv
// Directed bench for gmii_udp_video_rx: a 2-byte-pixel instance plus a 3-byte-pixel
// instance sharing the same GMII stimulus.
module tb_gmii_udp_video_rx;

  logic        clk125 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  rxd = '0;
  logic        rx_dv = 1'b0;
  logic [1:0]  ch_en = 2'b11;

  logic [15:0] pix_data;
  logic [3:0]  pix_ch;
  logic [11:0] pix_y;
  logic [3:0]  pix_x;
  logic        pix_valid, pkt_start, pkt_done, pkt_err;
  logic [15:0] drop_cnt;
  logic [2:0]  state_dbg;

  logic [23:0] pix_data3;
  logic [3:0]  pix_ch3;
  logic [11:0] pix_y3;
  logic [3:0]  pix_x3;
  logic        pix_valid3, pkt_start3, pkt_done3, pkt_err3;
  logic [15:0] drop_cnt3;
  logic [2:0]  state_dbg3;

  gmii_udp_video_rx #(.PIXEL_BYTES(2)) dut (
    .clk125(clk125), .sys_rst_n(sys_rst_n), .rxd(rxd), .rx_dv(rx_dv), .ch_en(ch_en),
    .pix_data(pix_data), .pix_ch(pix_ch), .pix_y(pix_y), .pix_x(pix_x),
    .pix_valid(pix_valid), .pkt_start(pkt_start), .pkt_done(pkt_done),
    .pkt_err(pkt_err), .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  gmii_udp_video_rx #(.PIXEL_BYTES(3)) dut3 (
    .clk125(clk125), .sys_rst_n(sys_rst_n), .rxd(rxd), .rx_dv(rx_dv), .ch_en(ch_en),
    .pix_data(pix_data3), .pix_ch(pix_ch3), .pix_y(pix_y3), .pix_x(pix_x3),
    .pix_valid(pix_valid3), .pkt_start(pkt_start3), .pkt_done(pkt_done3),
    .pkt_err(pkt_err3), .drop_cnt(drop_cnt3), .state_dbg(state_dbg3)
  );

  // clock/reset
  always #4 clk125 = ~clk125;

  int n_cmp = 0;
  int n_bad = 0;

  // Output monitor, sampled on the inactive edge.
  int cyc = 0, ps_cyc = 0, pd_cyc = 0, pv3_cyc = 0, pd3_cyc = 0;
  int pv_cnt = 0, ps_cnt = 0, pd_cnt = 0, pe_cnt = 0, pv3_cnt = 0;
  int first_lat = 0;
  bit seen_pv = 1'b0, pd_with_pv = 1'b0;
  logic [15:0] first_data = '0, last_data = '0;
  logic [3:0]  last_ch = '0, last_x = '0;
  logic [11:0] last_y = '0;
  logic [23:0] last3_data = '0;

  always @(negedge clk125) begin
    cyc++;
    if (pkt_start) begin ps_cnt++; ps_cyc = cyc; seen_pv = 1'b0; end
    if (pix_valid) begin
      pv_cnt++;
      last_data = pix_data; last_ch = pix_ch; last_y = pix_y; last_x = pix_x;
      if (!seen_pv) begin seen_pv = 1'b1; first_data = pix_data; first_lat = cyc - ps_cyc; end
    end
    if (pkt_done) begin pd_cnt++; pd_cyc = cyc; pd_with_pv = pix_valid; end
    if (pkt_err) pe_cnt++;
    if (pix_valid3) begin pv3_cnt++; pv3_cyc = cyc; last3_data = pix_data3; end
    if (pkt_done3) pd3_cyc = cyc;
  end

  // driver tasks
  logic [7:0] fr[$];

  task automatic build_frame(input logic [15:0] dport, input logic [15:0] ulen,
                             input logic [31:0] dip, input logic [15:0] etype,
                             input int npay, input bit fcs);
    fr.delete();
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 44; i++) begin
      logic [7:0] b;
      b = 8'(i + 8'h60);
      case (i)
        12: b = etype[15:8];
        13: b = etype[7:0];
        14: b = 8'h45;
        23: b = 8'h11;
        30: b = dip[31:24];
        31: b = dip[23:16];
        32: b = dip[15:8];
        33: b = dip[7:0];
        36: b = dport[15:8];
        37: b = dport[7:0];
        38: b = ulen[15:8];
        39: b = ulen[7:0];
        42: b = 8'h34;
        43: b = 8'h52;
        default: ;
      endcase
      fr.push_back(b);
    end
    for (int i = 0; i < npay; i++) fr.push_back(8'(i));
    if (fcs) repeat (4) fr.push_back(8'hEE);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk125);
  endtask

  task automatic drive_frame(input int gap);
    foreach (fr[i]) begin
      @(negedge clk125);
      rxd = fr[i];
      rx_dv = 1'b1;
    end
    @(negedge clk125);
    rx_dv = 1'b0;
    rxd = 8'h00;
    if (gap > 1) idle(gap - 1);
  endtask

  localparam logic [31:0] MY_IP = 32'hC0A80001;

  task automatic test_reset;
    sys_rst_n = 1'b0;
    idle(3);
    n_cmp++; if ({pix_valid, pkt_start, pkt_done, pkt_err} !== 4'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b expected 0000", {pix_valid, pkt_start, pkt_done, pkt_err}); end
    n_cmp++; if (drop_cnt !== 16'h0) begin
      n_bad++; $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt); end
    n_cmp++; if ({pix_data, pix_ch, pix_y, pix_x} !== 36'h0) begin
      n_bad++; $display("FAIL reset_pix_bus: got %h expected 0", {pix_data, pix_ch, pix_y, pix_x}); end
    sys_rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_good_frame;
    int pv0, ps0, pd0, pv30;
    pv0 = pv_cnt; ps0 = ps_cnt; pd0 = pd_cnt; pv30 = pv3_cnt;
    build_frame(16'd12346, 16'd1290, MY_IP, 16'h0800, 1280, 1'b1);
    drive_frame(1);
    idle(4);
    n_cmp++; if (ps_cnt - ps0 !== 1) begin n_bad++; $display("FAIL good_pkt_start: got %0d expected 1", ps_cnt - ps0); end
    n_cmp++; if (pv_cnt - pv0 !== 640) begin n_bad++; $display("FAIL good_pix_count: got %0d expected 640", pv_cnt - pv0); end
    n_cmp++; if (first_data !== 16'h0001) begin n_bad++; $display("FAIL good_first_pix: got %h expected 0001", first_data); end
    n_cmp++; if (first_lat !== 2) begin n_bad++; $display("FAIL good_first_latency: got %0d expected 2", first_lat); end
    n_cmp++; if (last_data !== 16'hFEFF) begin n_bad++; $display("FAIL good_last_pix: got %h expected feff", last_data); end
    n_cmp++; if (last_ch !== 4'd1) begin n_bad++; $display("FAIL good_pix_ch: got %0d expected 1", last_ch); end
    n_cmp++; if (last_y !== 12'h234) begin n_bad++; $display("FAIL good_pix_y: got %h expected 234", last_y); end
    n_cmp++; if (last_x !== 4'h5) begin n_bad++; $display("FAIL good_pix_x: got %h expected 5", last_x); end
    n_cmp++; if (pd_cnt - pd0 !== 1 || pd_with_pv !== 1'b1) begin
      n_bad++; $display("FAIL good_pkt_done: got count %0d with_strobe %0b expected 1 1", pd_cnt - pd0, pd_with_pv); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL good_drop_cnt: got %0d expected 0", drop_cnt); end
    n_cmp++; if (pv3_cnt - pv30 !== 426) begin n_bad++; $display("FAIL good_pix_count_pb3: got %0d expected 426", pv3_cnt - pv30); end
  endtask

  task automatic test_rejects;
    int pv0, ps0;
    pv0 = pv_cnt; ps0 = ps_cnt;
    build_frame(16'd12345, 16'd30, 32'hC0A80002, 16'h0800, 20, 1'b1);
    drive_frame(1); idle(2);
    n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL rej_dst_ip: got %0d expected 1", drop_cnt); end
    build_frame(16'd12347, 16'd30, MY_IP, 16'h0800, 20, 1'b1);
    drive_frame(1); idle(2);
    n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL rej_port_range: got %0d expected 2", drop_cnt); end
    build_frame(16'd12345, 16'd30, MY_IP, 16'h86DD, 20, 1'b1);
    drive_frame(1); idle(2);
    n_cmp++; if (drop_cnt !== 16'd3) begin n_bad++; $display("FAIL rej_ethertype: got %0d expected 3", drop_cnt); end
    n_cmp++; if (pv_cnt - pv0 !== 0 || ps_cnt - ps0 !== 0) begin
      n_bad++; $display("FAIL rej_no_output: got pix %0d start %0d expected 0 0", pv_cnt - pv0, ps_cnt - ps0); end
  endtask

  task automatic test_ch_disable;
    int ps0;
    ps0 = ps_cnt;
    ch_en = 2'b10;
    build_frame(16'd12345, 16'd30, MY_IP, 16'h0800, 20, 1'b1);
    drive_frame(1); idle(2);
    ch_en = 2'b11;
    n_cmp++; if (drop_cnt !== 16'd4) begin n_bad++; $display("FAIL chdis_drop_cnt: got %0d expected 4", drop_cnt); end
    n_cmp++; if (ps_cnt - ps0 !== 0) begin n_bad++; $display("FAIL chdis_no_start: got %0d expected 0", ps_cnt - ps0); end
  endtask

  task automatic test_trailing_bytes;
    int pv0, pv30;
    pv0 = pv_cnt; pv30 = pv3_cnt;
    build_frame(16'd12345, 16'd17, MY_IP, 16'h0800, 7, 1'b1);
    drive_frame(1); idle(3);
    n_cmp++; if (pv3_cnt - pv30 !== 2) begin n_bad++; $display("FAIL trail_pb3_count: got %0d expected 2", pv3_cnt - pv30); end
    n_cmp++; if (last3_data !== 24'h030405) begin n_bad++; $display("FAIL trail_pb3_data: got %h expected 030405", last3_data); end
    n_cmp++; if (pd3_cyc - pv3_cyc !== 1) begin n_bad++; $display("FAIL trail_pb3_done_gap: got %0d expected 1", pd3_cyc - pv3_cyc); end
    n_cmp++; if (pv_cnt - pv0 !== 3) begin n_bad++; $display("FAIL trail_pb2_count: got %0d expected 3", pv_cnt - pv0); end
    n_cmp++; if (pd_with_pv !== 1'b0 || last_ch !== 4'd0) begin
      n_bad++; $display("FAIL trail_pb2_done_ch: got with_strobe %0b ch %0d expected 0 0", pd_with_pv, last_ch); end
  endtask

  task automatic test_length_bounds;
    int pv0, ps0, pd0;
    pv0 = pv_cnt; ps0 = ps_cnt; pd0 = pd_cnt;
    build_frame(16'd12346, 16'd10, MY_IP, 16'h0800, 0, 1'b1);
    drive_frame(1); idle(2);
    n_cmp++; if (ps_cnt - ps0 !== 1 || pd_cnt - pd0 !== 1 || pv_cnt - pv0 !== 0) begin
      n_bad++; $display("FAIL len0_events: got start %0d done %0d pix %0d expected 1 1 0", ps_cnt - ps0, pd_cnt - pd0, pv_cnt - pv0); end
    n_cmp++; if (pd_cyc - ps_cyc !== 1) begin n_bad++; $display("FAIL len0_done_gap: got %0d expected 1", pd_cyc - ps_cyc); end
    build_frame(16'd12345, 16'd9, MY_IP, 16'h0800, 10, 1'b1);
    drive_frame(1); idle(2);
    n_cmp++; if (drop_cnt !== 16'd5) begin n_bad++; $display("FAIL len_below_min: got %0d expected 5", drop_cnt); end
    build_frame(16'd12345, 16'd1291, MY_IP, 16'h0800, 10, 1'b1);
    drive_frame(1); idle(2);
    n_cmp++; if (drop_cnt !== 16'd6) begin n_bad++; $display("FAIL len_above_max: got %0d expected 6", drop_cnt); end
  endtask

  task automatic test_runt;
    build_frame(16'd12345, 16'd30, MY_IP, 16'h0800, 0, 1'b0);
    fr = fr[0:27];
    drive_frame(1); idle(2);
    n_cmp++; if (drop_cnt !== 16'd7) begin n_bad++; $display("FAIL runt_drop_cnt: got %0d expected 7", drop_cnt); end
  endtask

  task automatic test_back_to_back;
    int pv0, ps0, pd0, pe0;
    pv0 = pv_cnt; ps0 = ps_cnt; pd0 = pd_cnt; pe0 = pe_cnt;
    build_frame(16'd12346, 16'd1290, MY_IP, 16'h0800, 101, 1'b0);
    drive_frame(1);
    build_frame(16'd12345, 16'd30, MY_IP, 16'h0800, 20, 1'b1);
    drive_frame(1); idle(3);
    n_cmp++; if (pv_cnt - pv0 !== 60) begin n_bad++; $display("FAIL b2b_pix_count: got %0d expected 60", pv_cnt - pv0); end
    n_cmp++; if (pe_cnt - pe0 !== 1) begin n_bad++; $display("FAIL b2b_pkt_err: got %0d expected 1", pe_cnt - pe0); end
    n_cmp++; if (ps_cnt - ps0 !== 2 || pd_cnt - pd0 !== 1) begin
      n_bad++; $display("FAIL b2b_start_done: got %0d %0d expected 2 1", ps_cnt - ps0, pd_cnt - pd0); end
    n_cmp++; if (drop_cnt !== 16'd7) begin n_bad++; $display("FAIL b2b_drop_cnt: got %0d expected 7", drop_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    int pv0, pd0, ps0;
    build_frame(16'd12346, 16'd1290, MY_IP, 16'h0800, 1280, 1'b1);
    pv0 = pv_cnt;
    foreach (fr[i]) begin
      @(negedge clk125);
      rxd = fr[i];
      rx_dv = 1'b1;
      if (i == 8 + 44 + 200) begin
        sys_rst_n = 1'b0;
        #1;
        n_cmp++; if ({pix_valid, pkt_start, pkt_done, pkt_err} !== 4'b0 || drop_cnt !== 16'd0) begin
          n_bad++; $display("FAIL midrst_outputs: got %b drop %0d expected 0000 0", {pix_valid, pkt_start, pkt_done, pkt_err}, drop_cnt); end
        n_cmp++; if (pix_data !== 16'h0) begin n_bad++; $display("FAIL midrst_pix_data: got %h expected 0000", pix_data); end
      end
      if (i == 8 + 44 + 202) begin
        sys_rst_n = 1'b1;
        pv0 = pv_cnt; pd0 = pd_cnt; ps0 = ps_cnt;
      end
    end
    @(negedge clk125);
    rx_dv = 1'b0;
    idle(2);
    n_cmp++; if (pv_cnt - pv0 !== 0 || pd_cnt - pd0 !== 0 || ps_cnt - ps0 !== 0) begin
      n_bad++; $display("FAIL midrst_rest_silent: got pix %0d done %0d start %0d expected 0 0 0", pv_cnt - pv0, pd_cnt - pd0, ps_cnt - ps0); end
    pv0 = pv_cnt; pd0 = pd_cnt;
    build_frame(16'd12345, 16'd30, MY_IP, 16'h0800, 20, 1'b1);
    drive_frame(1); idle(3);
    n_cmp++; if (pv_cnt - pv0 !== 10 || pd_cnt - pd0 !== 1) begin
      n_bad++; $display("FAIL midrst_next_frame: got pix %0d done %0d expected 10 1", pv_cnt - pv0, pd_cnt - pd0); end
    n_cmp++; if (last_data !== 16'h1213) begin n_bad++; $display("FAIL midrst_next_data: got %h expected 1213", last_data); end
  endtask

  task automatic test_drop_saturation;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk125); rxd = 8'h55; rx_dv = 1'b1;
      @(negedge clk125); rxd = 8'hD5;
      @(negedge clk125); rx_dv = 1'b0; rxd = 8'h00;
    end
    idle(2);
    n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_drop_cnt: got %h expected ffff", drop_cnt); end
    n_cmp++; if (drop_cnt3 !== 16'hFFFF) begin n_bad++; $display("FAIL sat_drop_cnt_pb3: got %h expected ffff", drop_cnt3); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_rejects;
    test_ch_disable;
    test_trailing_bytes;
    test_length_bounds;
    test_runt;
    test_back_to_back;
    test_reset_mid_frame;
    test_drop_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gmii_udp_video_rx.md
# gmii_udp_video_rx

Parametrised GMII receiver for UDP-carried video, successor to the single-channel 24-bit receive path. It sits between the GMII PHY receive interface (clk125 domain) and the per-channel pixel FIFOs. It parses Ethernet/IPv4/UDP headers with a state machine and steers packets to one of NUM_CH channels by UDP destination port. It takes the payload length from the UDP length field, packs PIXEL_BYTES-wide pixels, and reports per-packet status and a drop count.

## Interface
- IPV4_DST, 32'hC0A80001, accepted IPv4 destination address (all 32 bits compared)
- DST_PORT_BASE, 16'd12345, UDP port of channel 0; channel n uses DST_PORT_BASE+n
- NUM_CH, 2, channel count, 1..16
- CH_W, 4, width of pix_ch; must satisfy 2^CH_W >= NUM_CH
- PIXEL_BYTES, 2, bytes per pixel word, 2..4
- MAX_PAYLOAD, 1280, maximum video payload bytes (UDP length minus 10)
- clk125  in  1  125 MHz GMII receive clock; only clock
- sys_rst_n  in  1  asynchronous, active-low reset
- rxd  in  8  GMII receive data
- rx_dv  in  1  GMII receive data valid
- ch_en  in  NUM_CH  per-channel accept enable; sampled at the decision byte
- pix_data  out  8*PIXEL_BYTES  packed pixel, first received byte in MSBs
- pix_ch  out  CH_W  channel of pix_data
- pix_y  out  12  line number from video header
- pix_x  out  4  horizontal block index from video header
- pix_valid  out  1  one-cycle strobe qualifying pix_*
- pkt_start  out  1  pulse: packet accepted
- pkt_done  out  1  pulse: payload completed normally
- pkt_err  out  1  pulse: accepted packet truncated by rx_dv fall
- drop_cnt  out  16  saturating count of rejected frames

## Operation
- States: DROP, IDLE, PREAMBLE, HEADER, PAYLOAD.
- Reset enters DROP. All outputs are 0 in reset.
- DROP exits to IDLE on the first cycle with rx_dv=0. This prevents resynchronising mid-frame.
- IDLE: rx_dv=1 and rxd=8'h55 goes to PREAMBLE.
- PREAMBLE:
  - rxd=8'h55 stays in PREAMBLE.
  - rxd=8'hD5 goes to HEADER, with byte index 0 on the next byte.
  - Any other value goes to DROP without counting.
- HEADER captures by byte index:
  - 12-13 ethertype
  - 14 ver/IHL
  - 23 protocol
  - 30-33 dst IP
  - 36-37 dst port
  - 38-39 UDP length
  - 42 y[7:0]
  - 43 {x[3:0], y[11:8]}
- Decision is made on index 39. The frame is accepted only when all of these hold:
  - ethertype=16'h0800
  - ver/IHL=8'h45
  - protocol=8'h11
  - dst IP=IPV4_DST
  - (dst_port−DST_PORT_BASE) < NUM_CH, computed as 16-bit unsigned
  - ch_en[ch]=1
  - 10 <= UDP length <= MAX_PAYLOAD+10
- On reject: go to DROP and increment drop_cnt. drop_cnt saturates at 16'hFFFF.
- On accept: latch ch, and latch payload length = UDP length − 10 into a 16-bit counter.
- pkt_start pulses the cycle after index 43. The state enters PAYLOAD at index 44.
- PAYLOAD:
  - Bytes shift into a PIXEL_BYTES-deep pack register.
  - On the PIXEL_BYTES-th byte, pix_data/pix_ch/pix_y/pix_x are registered and pix_valid pulses.
- Trailing bytes (payload length mod PIXEL_BYTES) are discarded without pix_valid.
- After the last payload byte: pkt_done pulses and the state goes to DROP. FCS and padding are ignored.
- Payload length 0: pkt_start is followed by pkt_done on the next cycle, with no pix_valid.
- rx_dv=0 has priority over every other transition in every state:
  - From HEADER before index 39: counts as a drop (runt).
  - From HEADER after accept, or from PAYLOAD before the last byte: pkt_err pulses, the partial pixel is discarded, and drop_cnt is unchanged.
  - The next state is IDLE.
- pix_ch/pix_y/pix_x/pix_data hold their last values between strobes.

## Timing
- pix_valid is asserted exactly 1 cycle after the clk125 edge that samples the final byte of the pixel.
- Pixel throughput is one pix_valid per PIXEL_BYTES cycles. There is no backpressure, and pix_valid is never asserted on consecutive cycles when PIXEL_BYTES >= 2.
- pkt_done coincides with the final pix_valid when payload length is a multiple of PIXEL_BYTES. Otherwise it is 1 cycle after the last byte.
- pkt_err is asserted 1 cycle after the rx_dv=0 sample.
- drop_cnt updates 1 cycle after the decision or runt event.
- Back-to-back frames with a minimum 1-cycle rx_dv gap must be handled: the gap returns the FSM to IDLE.
- Asynchronous reset mid-frame clears outputs immediately. The remainder of that frame produces no output.

## Test plan
- NUM_CH=2, PIXEL_BYTES=2; frame to port 12346 with UDP length 1290, video header {0x34, 0x52}, payload 0x00..0xFF repeating -> pkt_start, 640 pix_valid with pix_ch=1, pix_y=12'h234, pix_x=4'h5, first pix_data=16'h0001, then pkt_done coincident with the last strobe.
- Wrong dst IP 192.168.0.2; then a frame to port 12347 (out of range); then ethertype 0x86DD -> no pix_valid, drop_cnt = 1, 2, 3.
- ch_en=2'b10 and a valid frame to port 12345 -> rejected, drop_cnt +1, no pkt_start.
- PIXEL_BYTES=3, payload 7 bytes -> 2 pix_valid (bytes 0-2, 3-5), byte 6 discarded, pkt_done 1 cycle after byte 6.
- rx_dv dropped after 101 payload bytes of an accepted frame -> 50 pix_valid, pkt_err pulse, drop_cnt unchanged. A following valid frame after a 1-cycle gap is received fully.
- sys_rst_n pulsed low at payload byte 200 -> outputs 0 during reset, no output for the rest of that frame, and the next frame is received normally. Also: 70000 rejected frames -> drop_cnt = 16'hFFFF.
